// File: rtl/shift_count_pkg.sv
// Shared types and defaults for the shift/count sequencer and its pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_count_pkg;

    // Width of the delay field shifted in after the start pattern.
    localparam int DATA_W_DEFAULT = 4;

    // Start-pattern length. The detector's history is sized from this.
    // The detector needs PAT_W >= 3.
    localparam int PAT_W = 4;

    // Default start pattern. PATTERN[PAT_W-1] is the first bit on the wire.
    localparam logic [PAT_W-1:0] PATTERN_DEFAULT = 4'b1101;

    // Sequencer states. The top maps these onto plain logic constants.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SHIFT  = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } seq_state_e;

    // Counter width for a modulus of n. A register is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_detector.sv
// Serial start-pattern matcher. It keeps the last PAT_W-1 bits and compares them,
// together with the live bit, against PATTERN.
// Latency: match is combinational in the same cycle the last pattern bit is on bit_in.
// Backpressure: none. A bit is consumed every cycle, and clr discards history.
//
// Ports:
//   clk     in  1  rising-edge clock
//   reset_n in  1  async active-low reset; clears history
//   clr     in  1  synchronous history clear; takes priority over shifting
//   bit_in  in  1  serial input bit
//   match   out 1  bit_in completes PATTERN on top of a full valid history
module pattern_detector
    import shift_count_pkg::*;
#(
    parameter logic [PAT_W-1:0] PATTERN = PATTERN_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic bit_in,
    output logic match
);

    // Previous PAT_W-1 bits. The newest bit is in the LSB.
    logic [PAT_W-2:0] hist_q, hist_d;

    // One flag per history slot: set once that slot holds a bit received
    // since the last clear. Without these flags, zeros loaded by reset or clr
    // could stand in for real zeros in the pattern.
    logic [PAT_W-2:0] fill_q, fill_d;

    // Candidate window that ends with the bit currently on the wire.
    logic [PAT_W-1:0] window;

    always_comb begin
        window = {hist_q, bit_in};
        match  = (&fill_q) && (window == PATTERN);

        hist_d = {hist_q[PAT_W-3:0], bit_in};
        fill_d = {fill_q[PAT_W-3:0], 1'b1};
        if (clr) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/shift_count_sequencer.sv
// Control sequencer: finds the start pattern, shifts in a DATA_W-bit delay MSB
// first, counts (delay+1)*TICKS_PER_UNIT cycles, then holds done until ack.
// Latency: shift_en starts 1 cycle after the pattern-completing edge. done rises
// the cycle after the last count_en cycle and falls the cycle after ack.
// Backpressure: none on data_in. ack is honoured only in DONE, where done is held.
//
// Ports:
//   clk       in  1       rising-edge clock
//   reset_n   in  1       async active-low reset (deassert synchronously to clk)
//   data_in   in  1       serial input, sampled every rising edge
//   ack       in  1       host acknowledge, honoured only while done is high
//   shift_en  out 1       delay field is being shifted in
//   count_en  out 1       countdown in progress
//   delay_out out DATA_W  delay register (remaining delay units)
//   done      out 1       countdown expired, waiting for ack
module shift_count_sequencer
    import shift_count_pkg::*;
#(
    parameter int               DATA_W         = DATA_W_DEFAULT,
    parameter logic [PAT_W-1:0] PATTERN        = PATTERN_DEFAULT,
    parameter int               TICKS_PER_UNIT = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              data_in,
    input  logic              ack,
    output logic              shift_en,
    output logic              count_en,
    output logic [DATA_W-1:0] delay_out,
    output logic              done
);

    // State constants are plain logic values so that legacy tools can read them.
    localparam logic [1:0] S_SEARCH = SEARCH;
    localparam logic [1:0] S_SHIFT  = SHIFT;
    localparam logic [1:0] S_COUNT  = COUNT;
    localparam logic [1:0] S_DONE   = DONE;

    localparam int TICK_W = cnt_width(TICKS_PER_UNIT);
    localparam int BIT_W  = cnt_width(DATA_W);

    // Terminal values. One unit is TICKS_PER_UNIT cycles, and the shift phase
    // is DATA_W samples.
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    logic [1:0]        state_q,   state_d;
    logic [DATA_W-1:0] delay_q,   delay_d;
    logic [TICK_W-1:0] tick_q,    tick_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;

    logic match;
    logic det_clr;

    // The detector runs every cycle. Its match output is used only in SEARCH.
    // Clearing it on the DONE->SEARCH edge means bits seen during SHIFT, COUNT
    // or DONE cannot complete a pattern afterwards.
    pattern_detector #(
        .PATTERN (PATTERN)
    ) u_detector (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (det_clr),
        .bit_in  (data_in),
        .match   (match)
    );

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        tick_d    = tick_q;
        bit_cnt_d = bit_cnt_q;
        det_clr   = 1'b0;

        case (state_q)
            S_SEARCH: begin
                if (match) begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = '0;
                end
            end

            S_SHIFT: begin
                // MSB first: earlier bits move toward the top of the register.
                delay_d = {delay_q[DATA_W-2:0], data_in};
                if (bit_cnt_q == BIT_LAST) begin
                    state_d = S_COUNT;
                    tick_d  = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end

            S_COUNT: begin
                // The unit that expires while delay is zero is the last one,
                // which gives D+1 units in total. delay therefore never steps
                // below zero.
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (delay_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        delay_d = delay_q - 1'b1;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end

            S_DONE: begin
                if (ack) begin
                    state_d = S_SEARCH;
                    det_clr = 1'b1;
                end
            end

            default: begin
                state_d = S_SEARCH;
                det_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_SEARCH;
            delay_q   <= '0;
            tick_q    <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            delay_q   <= delay_d;
            tick_q    <= tick_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Moore outputs: all status strobes are decoded from registered state only.
    assign shift_en  = (state_q == S_SHIFT);
    assign count_en  = (state_q == S_COUNT);
    assign done      = (state_q == S_DONE);
    assign delay_out = delay_q;

    // At most one status strobe is active at a time.
    a_one_phase: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({shift_en, count_en, done}));

    // Expiry of the final unit must end the count rather than wrap delay.
    a_no_wrap: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == S_COUNT && tick_q == TICK_LAST && delay_q == '0)
        |=> (state_q == S_DONE && delay_q == '0));

endmodule

// File: tb/tb_shift_count_sequencer.sv
module tb_shift_count_sequencer;

    localparam int         DW   = 4;
    localparam int         T    = 4;
    localparam int         MAXN = 512;
    localparam logic [3:0] PAT  = 4'b1101;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          data_in;
    logic          ack;
    logic          shift_en;
    logic          count_en;
    logic [DW-1:0] delay_out;
    logic          done;

    always #5 clk = ~clk;

    shift_count_sequencer #(
        .DATA_W         (DW),
        .PATTERN        (PAT),
        .TICKS_PER_UNIT (T)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .ack       (ack),
        .shift_en  (shift_en),
        .count_en  (count_en),
        .delay_out (delay_out),
        .done      (done)
    );

    int errors = 0;
    int checks = 0;

    // Planned stimulus per edge, observed and expected outputs after each edge.
    // Output vectors are packed as {shift_en, count_en, done, delay_out}.
    bit         s_data [MAXN];
    bit         s_ack  [MAXN];
    logic [6:0] obs    [MAXN];
    logic [6:0] expv   [MAXN];
    int         wp;

    task automatic clear_stream();
        for (int i = 0; i < MAXN; i++) begin
            s_data[i] = 1'b0;
            s_ack[i]  = 1'b0;
        end
        wp = 0;
    endtask

    // Append len bits of v, MSB first, at the write pointer.
    task automatic push(input logic [7:0] v, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            s_data[wp] = v[i];
            wp++;
        end
    endtask

    // Drive the planned stream one edge at a time and record outputs 1 time
    // unit after each rising edge. Edge 0 is the first edge after reset release.
    task automatic run_stream(input int n, input bit do_reset);
        if (do_reset) begin
            reset_n = 1'b0;
            data_in = 1'b0;
            ack     = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset_n = 1'b1;
        end
        for (int c = 0; c < n; c++) begin
            data_in = s_data[c];
            ack     = s_ack[c];
            @(posedge clk); #1;
            obs[c] = {shift_en, count_en, done, delay_out};
        end
        data_in = 1'b0;
        ack     = 1'b0;
    endtask

    // Reference model, computed from the stream as a whole.
    // Find the first 4-bit window equal to the pattern that lies fully after
    // the last clear. The next DW bits form D. The shift phase covers DW
    // observations and the count phase covers (D+1)*T observations, with
    // delay equal to D minus the elapsed whole units. Done lasts until the
    // first ack at least one cycle into DONE. The bit sampled with that ack
    // is discarded.
    task automatic model(input int n);
        int start, c, m, d, e, a;
        for (int i = 0; i < n; i++) expv[i] = 7'b0;
        start = 0;
        c     = 3;
        while (c < n) begin
            if ({s_data[c-3], s_data[c-2], s_data[c-1], s_data[c]} == PAT) begin
                m = c;
                d = 0;
                for (int k = 0; k < DW; k++) begin
                    if (m + k < n) expv[m+k] = {3'b100, 4'(d)};
                    d = d * 2 + ((m + k + 1 < n) ? int'(s_data[m+k+1]) : 0);
                end
                for (int j = 0; j < (d + 1) * T; j++)
                    if (m + DW + j < n) expv[m+DW+j] = {3'b010, 4'(d - j / T)};
                e = m + DW + (d + 1) * T;
                a = e + 1;
                while (a < n && !s_ack[a]) a++;
                for (int i = e; i < a && i < n; i++) expv[i] = 7'b0010000;
                start = a + 1;
                c     = start + 3;
            end else begin
                c++;
            end
        end
    endtask

    // Number of observations in which the given packed output bit was high.
    function automatic int count_bit(input int bitpos, input int n);
        int s = 0;
        for (int i = 0; i < n; i++) if (obs[i][bitpos]) s++;
        return s;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        data_in = 1'b1;
        ack     = 1'b1;
        #3;
        checks++;
        if ({shift_en, count_en, done, delay_out} !== 7'b0)
            begin errors++; $display("FAIL reset_async got %b want 0000000", {shift_en, count_en, done, delay_out}); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({shift_en, count_en, done, delay_out} !== 7'b0)
            begin errors++; $display("FAIL reset_held got %b want 0000000", {shift_en, count_en, done, delay_out}); end
        data_in = 1'b0;
        ack     = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0101, 4);
        // Done first appears after edge 31. Eleven cycles without ack follow, then ack.
        s_ack[42] = 1'b1;
        n = 50;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL basic cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(6, n) !== 4)  begin errors++; $display("FAIL basic_shift_len got %0d want 4", count_bit(6, n)); end
        checks++;
        if (count_bit(5, n) !== 24) begin errors++; $display("FAIL basic_count_len got %0d want 24", count_bit(5, n)); end
        checks++;
        if (obs[7][3:0] !== 4'd5)   begin errors++; $display("FAIL basic_first_delay got %0d want 5", obs[7][3:0]); end
        checks++;
        if ({obs[41][4], obs[42][4]} !== 2'b10)
            begin errors++; $display("FAIL basic_ack_release got %b want 10", {obs[41][4], obs[42][4]}); end
    endtask

    task automatic test_overlap();
        int n, first;
        clear_stream();
        push(8'b11101, 5);
        push(8'b0010, 4);
        s_ack[22] = 1'b1;
        n = 30;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL overlap cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        first = -1;
        for (int c = n - 1; c >= 0; c--) if (obs[c][6]) first = c;
        checks++;
        if (first !== 4) begin errors++; $display("FAIL overlap_first_shift got %0d want 4", first); end
    endtask

    task automatic test_delay_bounds();
        int  n;
        bit  rose;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0000, 4);
        s_ack[14] = 1'b1;
        n = 20;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL delay0 cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(5, n) !== 4) begin errors++; $display("FAIL delay0_count_len got %0d want 4", count_bit(5, n)); end

        clear_stream();
        push(8'b1101, 4);
        push(8'b1111, 4);
        s_ack[74] = 1'b1;
        n = 80;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL delay15 cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(5, n) !== 64) begin errors++; $display("FAIL delay15_count_len got %0d want 64", count_bit(5, n)); end
        rose = 1'b0;
        for (int c = 1; c < n; c++)
            if (obs[c][5] && obs[c-1][5] && obs[c][3:0] > obs[c-1][3:0]) rose = 1'b1;
        checks++;
        if (rose !== 1'b0) begin errors++; $display("FAIL delay15_wrap got %b want 0", rose); end
    endtask

    task automatic test_ack_ignored();
        int n;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0011, 4);
        for (int c = 0; c < 24; c++) s_ack[c] = 1'b1;
        for (int c = 8; c < 23; c++) s_data[c] = 1'($urandom_range(1));
        s_ack[34] = 1'b1;
        n = 40;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL ack_ignored cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(5, n) !== 16) begin errors++; $display("FAIL ack_count_len got %0d want 16", count_bit(5, n)); end
        checks++;
        if (count_bit(4, n) !== 11) begin errors++; $display("FAIL ack_done_len got %0d want 11", count_bit(4, n)); end
    endtask

    task automatic test_reset_mid_count();
        int n;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0110, 4);
        n = 17;
        run_stream(n, 1);
        checks++;
        if (count_en !== 1'b1) begin errors++; $display("FAIL midreset_setup got count_en=%b want 1", count_en); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({shift_en, count_en, done, delay_out} !== 7'b0)
            begin errors++; $display("FAIL midreset_async got %b want 0000000", {shift_en, count_en, done, delay_out}); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0001, 4);
        s_ack[17] = 1'b1;
        n = 22;
        run_stream(n, 0);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL midreset_restart cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(5, n) !== 8) begin errors++; $display("FAIL midreset_count_len got %0d want 8", count_bit(5, n)); end
    endtask

    task automatic test_pattern_ignored();
        int n;
        clear_stream();
        push(8'b1101, 4);
        push(8'b0010, 4);
        // The pattern repeats throughout COUNT and DONE. Done starts after edge 19.
        for (int c = 8; c < 23; c++) s_data[c] = PAT[3 - (c % 4)];
        s_data[23] = 1'b1; s_data[24] = 1'b1; s_data[25] = 1'b0;
        s_ack[25]  = 1'b1;
        s_data[26] = 1'b1;
        wp = 30;
        push(8'b1101, 4);
        push(8'b0001, 4);
        s_ack[47] = 1'b1;
        n = 50;
        run_stream(n, 1);
        model(n);
        for (int c = 0; c < n; c++) begin
            checks++;
            if (obs[c] !== expv[c])
                begin errors++; $display("FAIL pattern_ignored cycle %0d got %b want %b", c, obs[c], expv[c]); end
        end
        checks++;
        if (count_bit(6, n) !== 8) begin errors++; $display("FAIL pattern_shift_len got %0d want 8", count_bit(6, n)); end
        checks++;
        if (obs[26][6] !== 1'b0) begin errors++; $display("FAIL pattern_fresh_needed got shift_en=%b want 0", obs[26][6]); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            clear_stream();
            n = 300;
            for (int c = 0; c < n; c++) begin
                s_data[c] = 1'($urandom_range(1));
                s_ack[c]  = ($urandom_range(3) == 0);
            end
            run_stream(n, 1);
            model(n);
            for (int c = 0; c < n; c++) begin
                checks++;
                if (obs[c] !== expv[c])
                    begin errors++; $display("FAIL random%0d cycle %0d got %b want %b", it, c, obs[c], expv[c]); end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        data_in = 1'b0;
        ack     = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_delay_bounds();
        test_ack_ignored();
        test_reset_mid_count();
        test_pattern_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
